// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding and default width.
package div_pkg;

  localparam int unsigned DEF_W = 16;

  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StBusy = 2'd1;
  localparam state_t StDone = 2'd2;

endpackage

// File: rtl/div_restoring_step.sv
// One restoring division iteration: trial-subtract the divisor from the shifted partial remainder.
module div_restoring_step #(
  parameter int unsigned W = 16
) (
  input  logic [W:0]   prem,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] next_rem,
  output logic         q_bit
);

  logic [W+1:0] diff;
  logic         unused_diff_msb;

  assign diff     = {1'b0, prem} - {2'b00, divisor};
  assign q_bit    = ~diff[W+1];
  // A successful subtraction always leaves a result below the divisor, so bit W is zero.
  assign next_rem = q_bit ? diff[W-1:0] : prem[W-1:0];

  assign unused_diff_msb = diff[W];

endmodule

// File: rtl/div32u_restoring_seq.sv
// Sequential 2W/W unsigned restoring divider with valid/ready handshakes.
// Define DIV_ERR_FASTPATH_EN to send errored operands straight to DONE.
module div32u_restoring_seq
  import div_pkg::*;
#(
  parameter int unsigned W = DEF_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   quotient,
  output logic [W-1:0]   remainder,
  output logic           ovf
);

  localparam int unsigned CW = $clog2(W + 1);

  state_t        state_q, state_d;
  logic [W-1:0]  rem_q, rem_d;
  logic [W-1:0]  lo_q, lo_d;
  logic [W-1:0]  dvs_q, dvs_d;
  logic [W-1:0]  quo_q, quo_d;
  logic [W-1:0]  remo_q, remo_d;
  logic          err_q, err_d;
  logic          ovf_q, ovf_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          accept;
  logic          err_in;
  logic [W:0]    step_in;
  logic [W-1:0]  step_rem;
  logic          step_q;

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign accept    = in_valid && in_ready;
  // Upper half >= divisor means the quotient cannot fit in W bits.
  assign err_in    = (divisor == '0) || (dividend[2*W-1:W] >= divisor);

  // Lower dividend half shifts out MSB-first while quotient bits shift in at the bottom.
  assign step_in = {rem_q, lo_q[W-1]};

  div_restoring_step #(
    .W (W)
  ) u_step (
    .prem     (step_in),
    .divisor  (dvs_q),
    .next_rem (step_rem),
    .q_bit    (step_q)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    lo_d    = lo_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    remo_d  = remo_q;
    err_d   = err_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          rem_d   = dividend[2*W-1:W];
          lo_d    = dividend[W-1:0];
          dvs_d   = divisor;
          err_d   = err_in;
          cnt_d   = '0;
          state_d = StBusy;
`ifdef DIV_ERR_FASTPATH_EN
          if (err_in) begin
            quo_d   = '1;
            remo_d  = '0;
            ovf_d   = 1'b1;
            state_d = StDone;
          end
`endif
        end
      end
      StBusy: begin
        rem_d = step_rem;
        lo_d  = {lo_q[W-2:0], step_q};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(W - 1)) begin
          quo_d   = err_q ? '1 : {lo_q[W-2:0], step_q};
          remo_d  = err_q ? '0 : step_rem;
          ovf_d   = err_q;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      rem_q   <= '0;
      lo_q    <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      remo_q  <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      lo_q    <= lo_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      remo_q  <= remo_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = remo_q;
  assign ovf       = ovf_q;

endmodule

// File: doc/div32u_restoring_seq.md
DIV32U_RESTORING_SEQ -- requirements
Module: div32u_restoring_seq

Interface
REQ-001 SHALL have parameter W, default 16: divisor, quotient and remainder width; dividend width is 2*W.
REQ-002 SHALL have port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1: operands valid.
REQ-005 SHALL have port in_ready, output, 1: divider can accept operands.
REQ-006 SHALL have port dividend, input, 2*W: unsigned dividend.
REQ-007 SHALL have port divisor, input, W: unsigned divisor.
REQ-008 SHALL have port out_valid, output, 1: result valid.
REQ-009 SHALL have port out_ready, input, 1: consumer accepts result.
REQ-010 SHALL have port quotient, output, W: unsigned quotient.
REQ-011 SHALL have port remainder, output, W: unsigned remainder.
REQ-012 SHALL have port ovf, output, 1: divide-by-zero or quotient overflow.

Function
REQ-013 SHALL implement states IDLE, BUSY and DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE; an accept is in_valid && in_ready at a rising edge.
REQ-015 SHALL register dividend and divisor on accept, go to BUSY and clear the iteration counter to 0; inputs are ignored outside an accept.
REQ-016 SHALL flag an error on accept if divisor==0 or dividend[2W-1:W] >= divisor.
REQ-017 SHALL perform one restoring step per BUSY cycle: shift a (W+1)-bit partial remainder left, bring in the next dividend bit MSB-first, and subtract the divisor if the result is non-negative, setting the quotient bit.
REQ-018 SHALL execute exactly W BUSY cycles, then enter DONE; out_valid rises W+1 edges after the accept edge.
REQ-019 SHALL hold out_valid=1 and stable quotient, remainder and ovf in DONE until out_valid && out_ready, then return to IDLE on that edge.
REQ-020 SHALL NOT accept new operands in the DONE→IDLE handshake cycle (no overlap); the next accept occurs at the earliest one cycle later.
REQ-021 SHALL satisfy, for non-error results, dividend == quotient*divisor + remainder with remainder < divisor.
REQ-022 SHALL, on error, output ovf=1, quotient = all ones and remainder = 0; otherwise ovf=0.
REQ-023 SHALL leave out_valid=0 in IDLE and BUSY; quotient and remainder are don't-care there.

Reset
REQ-024 SHALL, on rst_n low, immediately enter IDLE with in_ready=1 and out_valid=0, and set quotient, remainder, ovf and the counter to 0, including mid-BUSY or mid-DONE; any in-flight operation is discarded.
REQ-025 SHALL release reset so that the first accept occurs on the first rising edge with rst_n high.

Configuration
REQ-026 SHALL use macro DIV_ERR_FASTPATH_EN: when defined, an errored accept goes directly to DONE, so out_valid rises 1 edge after accept.
REQ-027 SHALL, without DIV_ERR_FASTPATH_EN, run all W BUSY cycles for errored operations, with REQ-022 outputs and identical latency to the normal case.

Structure
REQ-028 SHALL place the state enum (IDLE/BUSY/DONE) and the default width constant in shared package div_pkg.
REQ-029 SHALL factor one restoring iteration (partial remainder, divisor in; next remainder, quotient bit out) into combinational sub-module div_restoring_step.

Verification
REQ-030 SHALL cover normal division: dividend=100000, divisor=300 -> quotient=333, remainder=100, ovf=0, out_valid 17 edges after accept (W=16).
REQ-031 SHALL cover maximum operands: dividend=0xFFFE0001, divisor=0xFFFF -> quotient=0xFFFF, remainder=0, ovf=0.
REQ-032 SHALL cover divide-by-zero: dividend=1234, divisor=0 -> ovf=1, quotient=0xFFFF, remainder=0; latency 1 with DIV_ERR_FASTPATH_EN, 17 without.
REQ-033 SHALL cover overflow: dividend=0x00010000, divisor=1 -> ovf=1, quotient=0xFFFF.
REQ-034 SHALL cover backpressure: out_ready held low 5 cycles after out_valid -> outputs stable, in_ready=0 throughout; in_valid asserted on the handshake cycle is not accepted until the next cycle.
REQ-035 SHALL cover reset mid-BUSY: rst_n pulsed low at iteration 8 -> out_valid=0, in_ready=1, and all outputs 0 immediately; a new 100000/300 then yields 333 r 100.
